// File: rtl/keypad_decimal_reader.sv
// keypad_decimal_reader
//   Scans a 4x4 active-low matrix keypad and debounces presses and releases.
//   Decimal digits are accumulated into a binary operand of up to MAX_DIGITS digits.
//   '*' clears the entry, '#' commits it, and A-D are debounced but otherwise ignored.
//
// Ports
//   clk_i           system clock
//   rst_ni          asynchronous active-low reset
//   row_i[3:0]      keypad rows, active-low, asynchronous to clk_i
//   col_o[3:0]      one-hot active-low column drive
//   entry_o[9:0]    binary value of the digits typed so far
//   digit_count_o   number of digits held in entry_o
//   number_o[9:0]   last committed operand
//   number_valid_o  one-cycle pulse when number_o is updated
module keypad_decimal_reader #(
  parameter int unsigned SCAN_CYCLES     = 27000,
  parameter int unsigned DEBOUNCE_CYCLES = 270000,
  parameter int unsigned MAX_DIGITS      = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [9:0] entry_o,
  output logic [1:0] digit_count_o,
  output logic [9:0] number_o,
  output logic       number_valid_o
);

  localparam int unsigned CntMax = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES
                                                                   : DEBOUNCE_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  localparam logic [CntW-1:0] ScanLast = CntW'(SCAN_CYCLES - 1);
  localparam logic [CntW-1:0] DebLast  = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]      DigMax   = 2'(MAX_DIGITS);

  // Key codes: 0..9 are digits.
  localparam logic [3:0] KeyClear = 4'd10;
  localparam logic [3:0] KeyEnter = 4'd11;
  localparam logic [3:0] KeyNone  = 4'd15;

  typedef enum logic [1:0] {
    StScan,
    StDebPress,
    StHeld,
    StDebRelease
  } state_e;

  // ---------------------------------------------------------------------------
  // Row synchronizer
  // ---------------------------------------------------------------------------
  logic [3:0] row_meta_q, row_sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= row_i;
      row_sync_q <= row_meta_q;
    end
  end

  logic row_idle;
  assign row_idle = (row_sync_q == 4'hF);

  // ---------------------------------------------------------------------------
  // Scan / debounce FSM
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      col_idx_q, col_idx_d;
  logic [3:0]      row_latch_q, row_latch_d;
  logic            key_event;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StScan;
      cnt_q       <= '0;
      col_idx_q   <= 2'd0;
      row_latch_q <= 4'hF;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_idx_q   <= col_idx_d;
      row_latch_q <= row_latch_d;
    end
  end

  // One counter serves both the column dwell and the debounce windows; it is
  // cleared on every state change so each window starts from zero.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    col_idx_d   = col_idx_q;
    row_latch_d = row_latch_q;
    unique case (state_q)
      StScan: begin
        if (!row_idle) begin
          row_latch_d = row_sync_q;
          cnt_d       = '0;
          state_d     = StDebPress;
        end else if (cnt_q == ScanLast) begin
          cnt_d     = '0;
          col_idx_d = col_idx_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDebPress: begin
        if (row_sync_q != row_latch_q) begin
          cnt_d   = '0;
          state_d = StScan;
        end else if (cnt_q == DebLast) begin
          cnt_d   = '0;
          state_d = StHeld;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHeld: begin
        if (row_idle) begin
          cnt_d   = '0;
          state_d = StDebRelease;
        end
      end
      StDebRelease: begin
        if (!row_idle) begin
          cnt_d   = '0;
          state_d = StHeld;
        end else if (cnt_q == DebLast) begin
          cnt_d   = '0;
          state_d = StScan;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StScan;
      end
    endcase
  end

  always_comb begin
    col_o     = ~(4'b0001 << col_idx_q);
    key_event = (state_q == StDebPress) && (row_sync_q == row_latch_q) && (cnt_q == DebLast);
  end

  // ---------------------------------------------------------------------------
  // Key decode: lowest low row wins when several rows are pressed together
  // ---------------------------------------------------------------------------
  logic [1:0] key_row;
  logic [3:0] key_code;

  always_comb begin
    key_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_latch_q[i]) key_row = 2'(i);
    end
  end

  always_comb begin
    key_code = KeyNone;
    case ({key_row, col_idx_q})
      4'b00_00: key_code = 4'd1;
      4'b00_01: key_code = 4'd2;
      4'b00_10: key_code = 4'd3;
      4'b01_00: key_code = 4'd4;
      4'b01_01: key_code = 4'd5;
      4'b01_10: key_code = 4'd6;
      4'b10_00: key_code = 4'd7;
      4'b10_01: key_code = 4'd8;
      4'b10_10: key_code = 4'd9;
      4'b11_00: key_code = KeyClear;
      4'b11_01: key_code = 4'd0;
      4'b11_10: key_code = KeyEnter;
      default:  key_code = KeyNone;   // A-D
    endcase
  end

  // ---------------------------------------------------------------------------
  // Decimal accumulator
  // ---------------------------------------------------------------------------
  logic [9:0] entry_q, entry_d;
  logic [1:0] count_q, count_d;
  logic [9:0] number_q, number_d;
  logic       valid_q, valid_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q  <= '0;
      count_q  <= '0;
      number_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      entry_q  <= entry_d;
      count_q  <= count_d;
      number_q <= number_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    entry_d  = entry_q;
    count_d  = count_q;
    number_d = number_q;
    valid_d  = 1'b0;
    if (key_event) begin
      if (key_code <= 4'd9) begin
        if (count_q < DigMax) begin
          // 14-bit product; with at most three digits the result is <= 999.
          entry_d = 10'(({4'b0000, entry_q} * 14'd10) + {10'b0, key_code});
          count_d = count_q + 2'd1;
        end
      end else if (key_code == KeyEnter) begin
        if (count_q != 2'd0) begin
          number_d = entry_q;
          valid_d  = 1'b1;
          entry_d  = '0;
          count_d  = '0;
        end
      end else if (key_code == KeyClear) begin
        entry_d = '0;
        count_d = '0;
      end
    end
  end

  assign entry_o        = entry_q;
  assign digit_count_o  = count_q;
  assign number_o       = number_q;
  assign number_valid_o = valid_q;

endmodule

// File: tb/tb_keypad_decimal_reader.sv
module tb_keypad_decimal_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [9:0] entry;
  logic [1:0] dcount;
  logic [9:0] number;
  logic       nvalid;

  always #5 clk = ~clk;

  keypad_decimal_reader #(
    .SCAN_CYCLES    (4),
    .DEBOUNCE_CYCLES(8),
    .MAX_DIGITS     (3)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .row_i         (row),
    .col_o         (col),
    .entry_o       (entry),
    .digit_count_o (dcount),
    .number_o      (number),
    .number_valid_o(nvalid)
  );

  // Physical keypad: a held key pulls its row low only while its column is driven.
  int   key_r = 0;
  int   key_c = 0;
  logic key_down = 1'b0;

  always_comb begin
    row = 4'hF;
    if (key_down && (col[key_c] == 1'b0)) row[key_r] = 1'b0;
  end

  // Pulse monitor
  int   pulses = 0;
  int   long_pulses = 0;
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (nvalid) begin
      pulses++;
      if (prev_valid) long_pulses++;
    end
    prev_valid = nvalid;
  end

  // Reference model: keypad meaning per key index r*4+c (-1 = ignored, 10 = '*', 11 = '#')
  int key_tbl [16] = '{1, 2, 3, -1, 4, 5, 6, -1, 7, 8, 9, -1, 10, 0, 11, -1};
  int m_entry = 0;
  int m_count = 0;
  int m_number = 0;
  int m_pulses = 0;

  localparam int KStar = 12;
  localparam int KHash = 14;

  function automatic int key_of(input int d);
    for (int i = 0; i < 16; i++) if (key_tbl[i] == d) return i;
    return 3;
  endfunction

  task automatic model_key(input int k);
    int v;
    v = key_tbl[k];
    if (v >= 0 && v <= 9) begin
      if (m_count < 3) begin
        m_entry = m_entry * 10 + v;
        m_count++;
      end
    end else if (v == 11) begin
      if (m_count > 0) begin
        m_number = m_entry;
        m_pulses++;
        m_entry = 0;
        m_count = 0;
      end
    end else if (v == 10) begin
      m_entry = 0;
      m_count = 0;
    end
  endtask

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".entry"}, int'(entry), m_entry);
    chk({tag, ".count"}, int'(dcount), m_count);
    chk({tag, ".number"}, int'(number), m_number);
    chk({tag, ".pulses"}, pulses, m_pulses);
  endtask

  task automatic wait_col(input logic [3:0] pat, input string tag);
    int n;
    n = 0;
    while (col != pat && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(col), int'(pat));
  endtask

  // Press key k with optional contact bounce on both edges, then release fully.
  task automatic press_key(input int k, input int bounces, input int hold, input int rbounces);
    key_r = k / 4;
    key_c = k % 4;
    for (int i = 0; i < bounces; i++) begin
      key_down = 1'b1;
      cycles(int'($urandom_range(4, 1)));
      key_down = 1'b0;
      cycles(int'($urandom_range(4, 1)));
    end
    key_down = 1'b1;
    cycles(hold);
    for (int i = 0; i < rbounces; i++) begin
      key_down = 1'b0;
      cycles(int'($urandom_range(4, 1)));
      key_down = 1'b1;
      cycles(int'($urandom_range(4, 1)));
    end
    key_down = 1'b0;
    cycles(20);
    model_key(k);
  endtask

  task automatic tap(input int k, input string tag);
    press_key(k, int'($urandom_range(2, 0)), int'($urandom_range(70, 40)),
              int'($urandom_range(2, 0)));
    check_state(tag);
  endtask

  initial begin
    logic [3:0] c0;
    int n;

    // Reset values
    rst_n = 1'b0;
    cycles(3);
    chk("rst.col", int'(col), 14);
    chk("rst.entry", int'(entry), 0);
    chk("rst.count", int'(dcount), 0);
    chk("rst.number", int'(number), 0);
    chk("rst.valid", int'(nvalid), 0);
    rst_n = 1'b1;
    cycles(2);

    // 1 2 3 #
    tap(key_of(1), "k1");
    chk("e1", int'(entry), 1);
    tap(key_of(2), "k12");
    chk("e12", int'(entry), 12);
    tap(key_of(3), "k123");
    chk("e123", int'(entry), 123);
    tap(KHash, "commit123");
    chk("num123", int'(number), 123);
    chk("pulse123", pulses, 1);
    chk("clr123", int'(dcount), 0);

    // 9 9 9 5 #: fourth digit ignored
    tap(key_of(9), "k9a");
    tap(key_of(9), "k9b");
    tap(key_of(9), "k9c");
    tap(key_of(5), "k5ign");
    chk("cap.count", int'(dcount), 3);
    chk("cap.entry", int'(entry), 999);
    tap(KHash, "commit999");
    chk("num999", int'(number), 999);

    // 4 5 * 7 #, then # alone
    tap(key_of(4), "k4");
    tap(key_of(5), "k45");
    chk("e45", int'(entry), 45);
    tap(KStar, "clear");
    chk("eclr", int'(entry), 0);
    tap(key_of(7), "k7");
    tap(KHash, "commit7");
    chk("num7", int'(number), 7);
    tap(KHash, "hash_empty");
    chk("num7_hold", int'(number), 7);

    // 5-cycle glitch on key 8: no event, rotation resumes
    wait_col(4'b1101, "glitch.col");
    key_r = 2;
    key_c = 1;
    key_down = 1'b1;
    cycles(5);
    key_down = 1'b0;
    cycles(6);
    check_state("glitch");
    c0 = col;
    n = 0;
    while (col == c0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("glitch.rotate", int'(col != c0), 1);

    // Key 8 with three press bounces
    press_key(key_of(8), 3, 50, 0);
    check_state("bounce8");
    chk("e8", int'(entry), 8);

    // Key 6 held 1000 cycles with release bounce, column frozen
    tap(KStar, "clear6");
    key_r = 1;
    key_c = 2;
    key_down = 1'b1;
    cycles(60);
    for (int i = 0; i < 9; i++) begin
      chk("held.col", int'(col), 11);
      cycles(100);
    end
    cycles(40);
    for (int i = 0; i < 2; i++) begin
      key_down = 1'b0;
      cycles(3);
      key_down = 1'b1;
      cycles(3);
    end
    key_down = 1'b0;
    cycles(20);
    model_key(6);
    check_state("hold6");
    chk("e6", int'(entry), 6);

    // Randomized key sequence
    for (int i = 0; i < 40; i++) begin
      tap(int'($urandom_range(15, 0)), "rand");
    end

    // Reset during debounce of a third key
    tap(KStar, "pre_rst");
    tap(key_of(2), "r2");
    tap(key_of(1), "r21");
    key_r = 0;
    key_c = 2;
    wait_col(4'b1011, "rst.wait");
    key_down = 1'b1;
    cycles(4);
    rst_n = 1'b0;
    #1;
    chk("mid.col", int'(col), 14);
    chk("mid.entry", int'(entry), 0);
    chk("mid.count", int'(dcount), 0);
    chk("mid.number", int'(number), 0);
    chk("mid.valid", int'(nvalid), 0);
    m_entry = 0;
    m_count = 0;
    m_number = 0;
    key_down = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(2);
    tap(key_of(3), "after3");
    tap(KHash, "after_commit");
    chk("num3", int'(number), 3);

    chk("single_cycle_pulse", long_pulses, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
